// File: rtl/fft_frame_scheduler.sv
// Two-source round-robin frame scheduler feeding an Avalon-ST FFT sink.
// A granted source streams exactly FRAME_LEN real samples; the imaginary part is tied to zero.
module fft_frame_scheduler #(
    parameter int FRAME_LEN = 8192,
    parameter int CNT_W     = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        src0_req,
    input  logic        src1_req,
    output logic        src0_grant,
    output logic        src1_grant,
    input  logic [15:0] src0_data,
    input  logic [15:0] src1_data,
    input  logic        src0_valid,
    input  logic        src1_valid,
    output logic        src0_ready,
    output logic        src1_ready,
    input  logic        sink_ready,
    output logic [15:0] sink_real,
    output logic [15:0] sink_imag,
    output logic        sink_valid,
    output logic        sink_sop,
    output logic        sink_eop,
    output logic        active_ch,
    output logic        frame_done,
    output logic [15:0] frames_sent
);

    typedef enum logic [1:0] {IDLE, GRANT, STREAM, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_ch_q, last_ch_d;
    logic             active_q, active_d;
    logic [15:0]      frames_q, frames_d;

    logic streaming;
    logic xfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_ch_q <= 1'b1;   // channel 0 wins the first tie
            active_q  <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_ch_q <= last_ch_d;
            active_q  <= active_d;
            frames_q  <= frames_d;
        end
    end

    // Datapath muxing is purely combinational from the registered state.
    always_comb begin
        streaming  = (state_q == STREAM);
        sink_valid = streaming && (active_q ? src1_valid : src0_valid);
        xfer       = sink_valid && sink_ready;
        sink_real  = streaming ? (active_q ? src1_data : src0_data) : 16'h0000;
        sink_imag  = 16'h0000;
        src0_ready = streaming && !active_q && sink_ready;
        src1_ready = streaming &&  active_q && sink_ready;
        src0_grant = ((state_q == GRANT) || streaming) && !active_q;
        src1_grant = ((state_q == GRANT) || streaming) &&  active_q;
        sink_sop   = streaming && (cnt_q == '0);
        sink_eop   = streaming && (cnt_q == LAST);
        frame_done = (state_q == DONE);
        active_ch  = active_q;
        frames_sent = frames_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_ch_d = last_ch_q;
        active_d  = active_q;
        frames_d  = frames_q;
        case (state_q)
            IDLE: begin
                if (src0_req && src1_req) begin
                    active_d = ~last_ch_q;
                    state_d  = GRANT;
                end else if (src0_req) begin
                    active_d = 1'b0;
                    state_d  = GRANT;
                end else if (src1_req) begin
                    active_d = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                // Requests are ignored here; the frame always runs to its eop transfer.
                if (xfer) begin
                    if (cnt_q == LAST) state_d = DONE;
                    else               cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                last_ch_d = active_q;
                frames_d  = frames_q + 16'd1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler with FRAME_LEN=8: expected samples are queued
// when a frame is requested and popped as the sink presents them.
module tb_fft_frame_scheduler;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        src0_req, src1_req, src0_grant, src1_grant;
    logic [15:0] src0_data, src1_data;
    logic        src0_valid, src1_valid, src0_ready, src1_ready;
    logic        sink_ready;
    logic [15:0] sink_real, sink_imag;
    logic        sink_valid, sink_sop, sink_eop, active_ch, frame_done;
    logic [15:0] frames_sent;

    fft_frame_scheduler #(.FRAME_LEN(FL), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .src0_req(src0_req), .src1_req(src1_req),
        .src0_grant(src0_grant), .src1_grant(src1_grant),
        .src0_data(src0_data), .src1_data(src1_data),
        .src0_valid(src0_valid), .src1_valid(src1_valid),
        .src0_ready(src0_ready), .src1_ready(src1_ready),
        .sink_ready(sink_ready), .sink_real(sink_real), .sink_imag(sink_imag),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .active_ch(active_ch), .frame_done(frame_done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   idx[2]  = '{0, 0};   // source position within the current frame
    int   fr[2]   = '{0, 0};   // frames completed by each source
    int   pf[2]   = '{0, 0};   // frames queued as expected per source
    int   exp_frames = 0;
    logic eop_prev   = 1'b0;
    logic done_prev  = 1'b0;
    int   bp_n = 0;
    int   gap_left = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sdata(input int ch, input int f, input int i);
        return {4'(ch + 1), 4'(f), 8'(i)};
    endfunction

    task automatic push_frame(input int ch);
        exp_t e;
        for (int i = 0; i < FL; i++) begin
            e.ch   = ch[0];
            e.data = sdata(ch, pf[ch], i);
            e.sop  = (i == 0);
            e.eop  = (i == FL - 1);
            sbq.push_back(e);
        end
        pf[ch]++;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_grants"}, {src0_grant, src1_grant}, 0);
        chk({tag, "_readys"}, {src0_ready, src1_ready}, 0);
        chk({tag, "_qual"}, {sink_valid, sink_sop, sink_eop, frame_done}, 0);
        chk({tag, "_active"}, active_ch, 0);
        chk({tag, "_frames"}, frames_sent, 0);
    endtask

    // One clock: drive at the falling edge, observe 1 ns later; mode 1 = ready pattern 1,0,0,1,
    // mode 2 = src1_valid gap of 3 cycles after its 4th sample.
    task automatic cyc(input int mode);
        exp_t e;
        @(negedge clk);
        if (mode == 1) begin
            sink_ready = (bp_n % 4 == 0) || (bp_n % 4 == 3);
            bp_n++;
        end
        if (mode == 2) begin
            src1_valid = !(idx[1] == 4 && gap_left > 0);
            if (!src1_valid) gap_left--;
        end
        src0_data = sdata(0, fr[0], idx[0]);
        src1_data = sdata(1, fr[1], idx[1]);
        #1;
        chk("frame_done", frame_done, eop_prev);
        if (eop_prev) begin
            chk("done_grants", {src0_grant, src1_grant}, 0);
            exp_frames = (exp_frames + 1) % 65536;
        end
        if (done_prev) begin
            chk("frames_sent", frames_sent, exp_frames);
            chk("idle_gap_grants", {src0_grant, src1_grant}, 0);
        end
        done_prev = eop_prev;
        eop_prev  = 1'b0;
        if (mode == 2 && !src1_valid) chk("gap_sink_valid", sink_valid, 0);
        if (src0_grant) chk("src1_ready_in_ch0", src1_ready, 0);
        if (sink_valid) begin
            if (sbq.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = sbq[0];
                chk("active_ch", active_ch, e.ch);
                chk("sink_real", sink_real, e.data);
                chk("sink_imag", sink_imag, 0);
                chk("sink_sop", sink_sop, e.sop);
                chk("sink_eop", sink_eop, e.eop);
                chk("own_grant", e.ch ? src1_grant : src0_grant, 1);
                chk("other_ready", e.ch ? src0_ready : src1_ready, 0);
                chk("own_ready", e.ch ? src1_ready : src0_ready, sink_ready);
                if (sink_ready) begin
                    void'(sbq.pop_front());
                    idx[e.ch]++;
                    if (e.eop) begin
                        eop_prev  = 1'b1;
                        idx[e.ch] = 0;
                        fr[e.ch]++;
                    end
                end
            end
        end
    endtask

    task automatic run_frames(input int mode, input int budget, input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            cyc(mode);
            n++;
        end
        if (sbq.size() != 0) begin
            chk({tag, "_timeout"}, sbq.size(), 0);
            sbq.delete();
        end
        src0_req   = 1'b0;
        src1_req   = 1'b0;
        sink_ready = 1'b1;
        src1_valid = 1'b1;
        cyc(0);
        cyc(0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero_outs(tag);
        sbq.delete();
        idx = '{0, 0};
        exp_frames = 0;
        eop_prev   = 1'b0;
        done_prev  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        src0_req = 1'b0; src1_req = 1'b0;
        src0_valid = 1'b1; src1_valid = 1'b1;
        src0_data = '0; src1_data = '0;
        sink_ready = 1'b1;
        #12;
        chk_zero_outs("reset");

        // Single source frame on channel 0
        @(negedge clk);
        reset = 1'b0;
        src0_req = 1'b1;
        push_frame(0);
        cyc(0);
        chk("grant_cycle1", src0_grant, 1);
        chk("grant_no_valid", sink_valid, 0);
        run_frames(0, 40, "single");
        chk("single_frames", frames_sent, 1);

        // Round robin from fresh reset: 0,1,0
        do_reset("rst_rr");
        src0_req = 1'b1; src1_req = 1'b1;
        push_frame(0); push_frame(1); push_frame(0);
        run_frames(0, 80, "rr");
        chk("rr_frames", frames_sent, 3);

        // Backpressure on channel 1
        src1_req = 1'b1;
        push_frame(1);
        bp_n = 0;
        run_frames(1, 80, "bp");

        // Valid gap on channel 1
        src1_req = 1'b1;
        push_frame(1);
        gap_left = 3;
        run_frames(2, 60, "gap");
        chk("gap_consumed", gap_left, 0);

        // Reset after the 5th transfer of a channel-0 frame
        src0_req = 1'b1;
        push_frame(0);
        n = 0;
        while (idx[0] < 5 && n < 30) begin cyc(0); n++; end
        chk("pre_abort_pos", idx[0], 5);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_zero_outs("abort");
        chk("abort_real", sink_real, 0);
        sbq.delete();
        idx[0] = 0;
        pf[0]--;
        exp_frames = 0;
        eop_prev = 1'b0; done_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        push_frame(0);
        run_frames(0, 40, "restart");
        chk("restart_frames", frames_sent, 1);

        // frames_sent wrap from 65535
        @(negedge clk);
        force dut.frames_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frames_q;
        exp_frames = 65535;
        cyc(0);
        chk("preload", frames_sent, 16'hFFFF);
        src1_req = 1'b1;
        push_frame(1);
        run_frames(0, 40, "wrap");
        chk("wrap_frames", frames_sent, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
